// File: rtl/event_buffer.sv
// Event capture stage behind the hit latches: waits a settle window after trigger,
// queues {timestamp, hit pattern} into a show-ahead FIFO, then clears and re-arms the latches.
module event_buffer #(
   parameter int unsigned WIDTH         = 24,
   parameter int unsigned TS_WIDTH      = 16,
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned HOLDOFF       = 16,
   parameter int unsigned CLEAR_CYCLES  = 4,
   parameter int unsigned REARM_TIMEOUT = 255
) (
   input  logic                         sys_clk_pll,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             hit_q,
   input  logic                         hit_trigger,
   output logic                         latch_clear,
   input  logic                         rd_en,
   output logic [TS_WIDTH+WIDTH-1:0]    rd_data,
   output logic                         rd_valid,
   output logic [$clog2(DEPTH):0]       fifo_count,
   output logic                         overflow,
   output logic [7:0]                   drop_count,
   output logic                         busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned MAX_HC = (HOLDOFF > CLEAR_CYCLES) ? HOLDOFF : CLEAR_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_HC > REARM_TIMEOUT) ? MAX_HC : REARM_TIMEOUT;
   localparam int unsigned CW = $clog2(CNT_MAX + 1);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_CLEAR,
      S_REARM
   } state_t;

   state_t                      state, state_nx;
   logic [CW-1:0]               cnt, cnt_nx;
   logic [TS_WIDTH-1:0]         ts_cnt, ts_hold;
   logic [TS_WIDTH+WIDTH-1:0]   mem [DEPTH];
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic                        capture, push, pop, drop, inputs_empty;

   assign inputs_empty = !hit_trigger && (hit_q == '0);
   assign rd_valid     = (fifo_count != '0);
   assign rd_data      = rd_valid ? mem[rd_ptr] : '0;
   assign pop          = rd_en && rd_valid;
   // A full FIFO still accepts the capture when the head is popped in the same cycle.
   assign push         = capture && ((fifo_count != FULL) || pop);
   assign drop         = capture && !push;

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      latch_clear = 1'b0;
      capture     = 1'b0;
      busy        = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (hit_trigger) begin
               state_nx = S_SETTLE;
               cnt_nx   = CW'(HOLDOFF - 1);
            end
         end
         S_SETTLE: begin
            if (cnt == '0) state_nx = S_CAPTURE;
            else           cnt_nx   = cnt - CW'(1);
         end
         S_CAPTURE: begin
            capture  = 1'b1;
            state_nx = S_CLEAR;
            cnt_nx   = CW'(CLEAR_CYCLES - 1);
         end
         S_CLEAR: begin
            latch_clear = 1'b1;
            if (cnt == '0) begin
               state_nx = S_REARM;
               cnt_nx   = CW'(REARM_TIMEOUT - 1);
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         S_REARM: begin
            // Latches that never read empty get cleared again (stuck-channel recovery).
            if (inputs_empty) begin
               state_nx = S_IDLE;
            end else if (cnt == '0) begin
               state_nx = S_CLEAR;
               cnt_nx   = CW'(CLEAR_CYCLES - 1);
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_pll) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         ts_cnt     <= '0;
         ts_hold    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         ts_cnt <= ts_cnt + TS_WIDTH'(1);
         if ((state == S_IDLE) && hit_trigger) ts_hold <= ts_cnt;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
         else if (pop && !push) fifo_count <= fifo_count - (AW+1)'(1);
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 8'd1;
         end
      end
   end

   always_ff @(posedge sys_clk_pll) begin
      if (push) mem[wr_ptr] <= {ts_hold, hit_q};
   end

endmodule

// File: tb/tb_event_buffer.sv
// Directed bench for event_buffer: default instance for the main scenarios, a short-holdoff
// instance for timestamp wrap. Inputs change and outputs are sampled on the falling edge.
module tb_event_buffer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, hit_trigger, rd_en, latch_clear, rd_valid, overflow, busy;
   logic [23:0] hit_q;
   logic [39:0] rd_data;
   logic [3:0]  fifo_count;
   logic [7:0]  drop_count;

   logic        rst_b, hit_trigger_b, rd_en_b, latch_clear_b, rd_valid_b, overflow_b, busy_b;
   logic [23:0] hit_q_b;
   logic [39:0] rd_data_b;
   logic [3:0]  fifo_count_b;
   logic [7:0]  drop_count_b;

   int errors = 0;
   int checks = 0;
   logic [15:0] ts_model, tsb_model;

   event_buffer dut (
      .sys_clk_pll(clk), .rst(rst), .hit_q(hit_q), .hit_trigger(hit_trigger),
      .latch_clear(latch_clear), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count), .busy(busy)
   );

   event_buffer #(.HOLDOFF(1), .CLEAR_CYCLES(1)) dut_b (
      .sys_clk_pll(clk), .rst(rst_b), .hit_q(hit_q_b), .hit_trigger(hit_trigger_b),
      .latch_clear(latch_clear_b), .rd_en(rd_en_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
      .fifo_count(fifo_count_b), .overflow(overflow_b), .drop_count(drop_count_b), .busy(busy_b)
   );

   // Expected free-running timestamp: value at a falling edge is what the next rising edge samples.
   always @(posedge clk) ts_model  <= rst   ? 16'h0 : ts_model + 16'h1;
   always @(posedge clk) tsb_model <= rst_b ? 16'h0 : tsb_model + 16'h1;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; hit_trigger = 1'b0; hit_q = '0; rd_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic fire_event(input logic [23:0] pat);
      bit got;
      hit_q = pat; hit_trigger = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = latch_clear; end
      hit_trigger = 1'b0; hit_q = '0;
      checks++;
      if (!got) begin errors++; $display("FAIL event_clear_wait: latch_clear=0 after 40 cycles, expected 1"); end
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = !busy; end
      checks++;
      if (!got) begin errors++; $display("FAIL event_idle_wait: busy=1 after 20 cycles, expected 0"); end
   endtask

   task automatic test_reset();
      bit seen_lc = 1'b0, seen_busy = 1'b0, seen_valid = 1'b0;
      do_reset();
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (rd_valid !== 1'b0)   begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      checks++; if (latch_clear !== 1'b0) begin errors++; $display("FAIL reset_latch_clear: got %b expected 0", latch_clear); end
      checks++; if (overflow !== 1'b0 || drop_count !== 8'd0)
         begin errors++; $display("FAIL reset_overflow: got ovf=%b drops=%0d expected 0/0", overflow, drop_count); end
      checks++; if (rd_data !== 40'h0)   begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (latch_clear) seen_lc = 1'b1;
         if (busy) seen_busy = 1'b1;
         if (rd_valid) seen_valid = 1'b1;
      end
      checks++; if (seen_lc || seen_busy || seen_valid)
         begin errors++; $display("FAIL idle_quiet: lc=%b busy=%b valid=%b expected 0/0/0", seen_lc, seen_busy, seen_valid); end
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_single_event();
      int first_valid = 0, lc_cnt = 0, lc_first = 0, idle_at = 0;
      logic [39:0] data_at_valid = '0;
      do_reset();
      for (int i = 0; i < 400 && ts_model != 16'h0100; i++) @(negedge clk);
      hit_q = 24'h00000F; hit_trigger = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (rd_valid && first_valid == 0) begin first_valid = n; data_at_valid = rd_data; end
         if (latch_clear) begin
            lc_cnt++;
            if (lc_first == 0) lc_first = n;
            hit_trigger = 1'b0; hit_q = '0;
         end
         if (!busy && idle_at == 0) idle_at = n;
      end
      checks++; if (first_valid != 18) begin errors++; $display("FAIL single_valid_time: got %0d expected 18", first_valid); end
      checks++; if (data_at_valid !== 40'h0100_00000F)
         begin errors++; $display("FAIL single_data: got %h expected 010000000f", data_at_valid); end
      checks++; if (lc_cnt != 4 || lc_first != 18)
         begin errors++; $display("FAIL single_clear_pulse: got len=%0d start=%0d expected 4/18", lc_cnt, lc_first); end
      checks++; if (idle_at != 23) begin errors++; $display("FAIL single_idle_time: got %0d expected 23", idle_at); end
      checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      checks++; if (rd_valid !== 1'b0 || fifo_count !== 4'd0)
         begin errors++; $display("FAIL single_pop: got valid=%b count=%0d expected 0/0", rd_valid, fifo_count); end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL empty_pop: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_fill();
      logic [39:0] exp_q[$];
      logic [23:0] pat;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         pat = 24'hA00000 + 24'(i);
         if (i < 8) exp_q.push_back({ts_model, pat});
         fire_event(pat);
      end
      checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", fifo_count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
      checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL fill_drops: got %0d expected 1", drop_count); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_q[i])
            begin errors++; $display("FAIL fill_pop%0d: got valid=%b data=%h expected 1/%h", i, rd_valid, rd_data, exp_q[i]); end
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
      checks++; if (rd_valid !== 1'b0 || fifo_count !== 4'd0)
         begin errors++; $display("FAIL fill_drained: got valid=%b count=%0d expected 0/0", rd_valid, fifo_count); end
      checks++; if (overflow !== 1'b1 || drop_count !== 8'd1)
         begin errors++; $display("FAIL fill_sticky: got ovf=%b drops=%0d expected 1/1", overflow, drop_count); end
   endtask

   task automatic test_pop_on_full();
      logic [39:0] exp_q[$];
      logic [23:0] pat;
      bit got;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         pat = 24'h050000 + 24'(i);
         exp_q.push_back({ts_model, pat});
         fire_event(pat);
      end
      pat = 24'h0500FF;
      exp_q.push_back({ts_model, pat});
      hit_q = pat; hit_trigger = 1'b1;
      repeat (17) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      checks++; if (latch_clear !== 1'b1) begin errors++; $display("FAIL pof_clear: got %b expected 1", latch_clear); end
      hit_trigger = 1'b0; hit_q = '0;
      checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL pof_count: got %0d expected 8", fifo_count); end
      checks++; if (overflow !== 1'b0 || drop_count !== 8'd0)
         begin errors++; $display("FAIL pof_no_drop: got ovf=%b drops=%0d expected 0/0", overflow, drop_count); end
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin @(negedge clk); got = !busy; end
      checks++; if (!got) begin errors++; $display("FAIL pof_idle_wait: busy=1 after 20 cycles, expected 0"); end
      for (int i = 1; i < 9; i++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_q[i])
            begin errors++; $display("FAIL pof_pop%0d: got valid=%b data=%h expected 1/%h", i, rd_valid, rd_data, exp_q[i]); end
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
   endtask

   task automatic test_stuck_channel();
      int rise[3] = '{0, 0, 0};
      int nr = 0, high = 0;
      logic prev = 1'b0;
      do_reset();
      hit_q = 24'h000020; hit_trigger = 1'b1;
      for (int n = 1; n <= 560; n++) begin
         @(negedge clk);
         if (latch_clear) begin
            high++;
            hit_trigger = 1'b0;
            if (!prev) begin
               if (nr < 3) rise[nr] = n;
               nr++;
            end
         end
         prev = latch_clear;
      end
      checks++; if (nr != 3 || rise[0] != 18 || rise[1] != 277 || rise[2] != 536)
         begin errors++; $display("FAIL stuck_repulse: got n=%0d at %0d/%0d/%0d expected 3 at 18/277/536", nr, rise[0], rise[1], rise[2]); end
      checks++; if (high != 12) begin errors++; $display("FAIL stuck_high_cycles: got %0d expected 12", high); end
      hit_q = '0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || latch_clear !== 1'b0)
         begin errors++; $display("FAIL stuck_release: got busy=%b lc=%b expected 0/0", busy, latch_clear); end
      checks++; if (fifo_count !== 4'd1 || drop_count !== 8'd0)
         begin errors++; $display("FAIL stuck_writes: got count=%0d drops=%0d expected 1/0", fifo_count, drop_count); end
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      bit got;
      do_reset();
      hit_q = 24'h000101; hit_trigger = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1; hit_trigger = 1'b0; hit_q = '0;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0 || latch_clear !== 1'b0 || fifo_count !== 4'd0)
         begin errors++; $display("FAIL rst_settle: got busy=%b lc=%b count=%0d expected 0/0/0", busy, latch_clear, fifo_count); end
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (latch_clear || rd_valid || busy) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL rst_settle_abandon: got activity=1 expected 0"); end
      hit_q = 24'h000202; hit_trigger = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = latch_clear; end
      checks++; if (!got || fifo_count !== 4'd1)
         begin errors++; $display("FAIL rst_clear_setup: got lc=%b count=%0d expected 1/1", got, fifo_count); end
      @(negedge clk);
      rst = 1'b1; hit_trigger = 1'b0; hit_q = '0;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (latch_clear !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL rst_clear_state: got lc=%b busy=%b expected 0/0", latch_clear, busy); end
      checks++; if (fifo_count !== 4'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0)
         begin errors++; $display("FAIL rst_clear_counts: got count=%0d valid=%b ovf=%b drops=%0d expected 0/0/0/0", fifo_count, rd_valid, overflow, drop_count); end
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin @(negedge clk); if (latch_clear) seen = 1'b1; end
      checks++; if (seen) begin errors++; $display("FAIL rst_clear_quiet: got lc pulse expected none"); end
   endtask

   task automatic test_ts_wrap();
      bit got;
      logic [23:0] pats[2] = '{24'h000AAA, 24'h000555};
      logic [15:0] tss[2]  = '{16'hFFFF, 16'h0005};
      for (int e = 0; e < 2; e++) begin
         for (int i = 0; i < 70000 && tsb_model != tss[e]; i++) @(negedge clk);
         hit_q_b = pats[e]; hit_trigger_b = 1'b1;
         got = 1'b0;
         for (int n = 0; n < 10 && !got; n++) begin @(negedge clk); got = latch_clear_b; end
         hit_q_b = '0; hit_trigger_b = 1'b0;
         checks++; if (!got) begin errors++; $display("FAIL wrap_clear_wait%0d: latch_clear=0 expected 1", e); end
         got = 1'b0;
         for (int n = 0; n < 10 && !got; n++) begin @(negedge clk); got = !busy_b; end
         checks++; if (!got) begin errors++; $display("FAIL wrap_idle_wait%0d: busy=1 expected 0", e); end
      end
      checks++; if (fifo_count_b !== 4'd2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", fifo_count_b); end
      checks++; if (rd_data_b !== 40'hFFFF_000AAA) begin errors++; $display("FAIL wrap_first: got %h expected ffff000aaa", rd_data_b); end
      rd_en_b = 1'b1;
      @(negedge clk);
      rd_en_b = 1'b0;
      checks++; if (rd_data_b !== 40'h0005_000555 || rd_valid_b !== 1'b1)
         begin errors++; $display("FAIL wrap_second: got valid=%b data=%h expected 1/0005000555", rd_valid_b, rd_data_b); end
   endtask

   initial begin
      rst = 1'b1; hit_trigger = 1'b0; hit_q = '0; rd_en = 1'b0;
      rst_b = 1'b1; hit_trigger_b = 1'b0; hit_q_b = '0; rd_en_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b0;
      test_reset();
      test_single_event();
      test_fill();
      test_pop_on_full();
      test_stuck_channel();
      test_reset_mid();
      test_ts_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
